// File: rtl/multicycle_control_if.sv
// ============================================================================
//  Module   : multicycle_control_if
//  Purpose  : Bundle of the sequencer's handshake inputs and all datapath
//             control outputs for the multicycle MIPS datapath.
//  Modports : master - the control sequencer (reads run/op/mem_ready,
//                      drives every enable and mux select)
//             slave  - the datapath / memory side (the reverse view)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_control_if;
   logic       run;
   logic [5:0] op;
   logic       mem_ready;

   logic       PCWrite;
   logic       PCWriteCond;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       MemtoReg;
   logic       RegDst;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic [1:0] PCSource;
   logic       instr_done;
   logic       illegal_op;

   modport master (
      input  run, op, mem_ready,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
             PCSource, instr_done, illegal_op
   );

   modport slave (
      output run, op, mem_ready,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
             PCSource, instr_done, illegal_op
   );
endinterface

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
//  Module   : multicycle_control
//  Purpose  : Multicycle MIPS control sequencer. Steps each instruction
//             through fetch, decode, execute, memory and writeback and
//             decodes every datapath enable/select from the current step.
//  Ports    : clk   - system clock, rising edge
//             rst_n - asynchronous active-low reset (forces IDLE)
//             ctrl  - multicycle_control_if.master: run, op, mem_ready in;
//                     PC/IR/memory/regfile/ALU controls, instr_done and
//                     illegal_op out
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control #(
   parameter logic [5:0] OP_RTYPE = 6'b000000,
   parameter logic [5:0] OP_ADDI  = 6'b001000,
   parameter logic [5:0] OP_LW    = 6'b100011,
   parameter logic [5:0] OP_SW    = 6'b101011,
   parameter logic [5:0] OP_BEQ   = 6'b000100,
   parameter logic [5:0] OP_J     = 6'b000010
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   multicycle_control_if.master   ctrl
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADR  = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_EXEC    = 4'd7,
      S_ALUWB_R = 4'd8,
      S_ALUWB_I = 4'd9,
      S_BRANCH  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   state_t r_state;
   state_t w_next;
   state_t w_retire;   // where an instruction goes once it retires

   // run is only looked at when an instruction retires (and in IDLE), so an
   // instruction in flight always completes.
   assign w_retire = ctrl.run ? S_FETCH : S_IDLE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next           = r_state;
      ctrl.PCWrite     = 1'b0;
      ctrl.PCWriteCond = 1'b0;
      ctrl.IorD        = 1'b0;
      ctrl.MemRead     = 1'b0;
      ctrl.MemWrite    = 1'b0;
      ctrl.IRWrite     = 1'b0;
      ctrl.MemtoReg    = 1'b0;
      ctrl.RegDst      = 1'b0;
      ctrl.RegWrite    = 1'b0;
      ctrl.ALUSrcA     = 1'b0;
      ctrl.ALUSrcB     = 2'b00;
      ctrl.ALUOp       = 2'b00;
      ctrl.PCSource    = 2'b00;
      ctrl.instr_done  = 1'b0;
      ctrl.illegal_op  = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (ctrl.run) w_next = S_FETCH;
         end
         S_FETCH: begin
            // IR and PC+4 are only captured on the cycle memory delivers.
            ctrl.MemRead = 1'b1;
            ctrl.ALUSrcB = 2'b01;
            ctrl.IRWrite = ctrl.mem_ready;
            ctrl.PCWrite = ctrl.mem_ready;
            if (ctrl.mem_ready) w_next = S_DECODE;
         end
         S_DECODE: begin
            // Speculatively compute the branch target into ALUOut.
            ctrl.ALUSrcB = 2'b11;
            case (ctrl.op)
               OP_RTYPE:              w_next = S_EXEC;
               OP_ADDI, OP_LW, OP_SW: w_next = S_MEMADR;
               OP_BEQ:                w_next = S_BRANCH;
               OP_J:                  w_next = S_JUMP;
               default: begin
                  ctrl.illegal_op = 1'b1;
                  ctrl.instr_done = 1'b1;
                  w_next          = w_retire;
               end
            endcase
         end
         S_MEMADR: begin
            // op is held in IR, so it is re-decoded to pick the next step.
            ctrl.ALUSrcA = 1'b1;
            ctrl.ALUSrcB = 2'b10;
            case (ctrl.op)
               OP_LW:   w_next = S_MEMRD;
               OP_SW:   w_next = S_MEMWR;
               OP_ADDI: w_next = S_ALUWB_I;
               default: w_next = S_IDLE;
            endcase
         end
         S_MEMRD: begin
            ctrl.MemRead = 1'b1;
            ctrl.IorD    = 1'b1;
            if (ctrl.mem_ready) w_next = S_MEMWB;
         end
         S_MEMWB: begin
            ctrl.RegWrite   = 1'b1;
            ctrl.MemtoReg   = 1'b1;
            ctrl.instr_done = 1'b1;
            w_next          = w_retire;
         end
         S_MEMWR: begin
            ctrl.MemWrite   = 1'b1;
            ctrl.IorD       = 1'b1;
            ctrl.instr_done = ctrl.mem_ready;
            if (ctrl.mem_ready) w_next = w_retire;
         end
         S_EXEC: begin
            ctrl.ALUSrcA = 1'b1;
            ctrl.ALUOp   = 2'b10;
            w_next       = S_ALUWB_R;
         end
         S_ALUWB_R: begin
            ctrl.RegWrite   = 1'b1;
            ctrl.RegDst     = 1'b1;
            ctrl.instr_done = 1'b1;
            w_next          = w_retire;
         end
         S_ALUWB_I: begin
            ctrl.RegWrite   = 1'b1;
            ctrl.instr_done = 1'b1;
            w_next          = w_retire;
         end
         S_BRANCH: begin
            ctrl.ALUSrcA     = 1'b1;
            ctrl.ALUOp       = 2'b01;
            ctrl.PCWriteCond = 1'b1;
            ctrl.PCSource    = 2'b01;
            ctrl.instr_done  = 1'b1;
            w_next           = w_retire;
         end
         S_JUMP: begin
            ctrl.PCWrite    = 1'b1;
            ctrl.PCSource   = 2'b10;
            ctrl.instr_done = 1'b1;
            w_next          = w_retire;
         end
         default: begin
            // Unused encodings recover to IDLE with everything deasserted.
            w_next = S_IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
//  Module   : tb_multicycle_control
//  Purpose  : Self-checking bench for multicycle_control: a directed vector
//             table, hand-written reset/run corner sequences and a random
//             phase compared against a step-list reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

   // Control word layout: {PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
   // IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0],
   // PCSource[1:0], instr_done, illegal_op}
   localparam logic [17:0] B_PCW    = 18'd1 << 17;
   localparam logic [17:0] B_PCWC   = 18'd1 << 16;
   localparam logic [17:0] B_IORD   = 18'd1 << 15;
   localparam logic [17:0] B_MRD    = 18'd1 << 14;
   localparam logic [17:0] B_MWR    = 18'd1 << 13;
   localparam logic [17:0] B_IRW    = 18'd1 << 12;
   localparam logic [17:0] B_M2R    = 18'd1 << 11;
   localparam logic [17:0] B_RDST   = 18'd1 << 10;
   localparam logic [17:0] B_RW     = 18'd1 << 9;
   localparam logic [17:0] B_SRCA   = 18'd1 << 8;
   localparam logic [17:0] SRCB_4   = 18'd1 << 6;
   localparam logic [17:0] SRCB_IMM = 18'd2 << 6;
   localparam logic [17:0] SRCB_BR  = 18'd3 << 6;
   localparam logic [17:0] ALU_SUB  = 18'd1 << 4;
   localparam logic [17:0] ALU_FN   = 18'd2 << 4;
   localparam logic [17:0] PCS_OUT  = 18'd1 << 2;
   localparam logic [17:0] PCS_J    = 18'd2 << 2;
   localparam logic [17:0] B_DONE   = 18'd2;
   localparam logic [17:0] B_ILL    = 18'd1;

   localparam logic [17:0] W_FETCH   = B_PCW | B_MRD | B_IRW | SRCB_4;
   localparam logic [17:0] G_FETCH   = B_PCW | B_IRW;
   localparam logic [17:0] W_DECODE  = SRCB_BR;
   localparam logic [17:0] W_MEMADR  = B_SRCA | SRCB_IMM;
   localparam logic [17:0] W_MEMRD   = B_IORD | B_MRD;
   localparam logic [17:0] W_MEMWB   = B_RW | B_M2R | B_DONE;
   localparam logic [17:0] W_MEMWR   = B_IORD | B_MWR | B_DONE;
   localparam logic [17:0] W_EXEC    = B_SRCA | ALU_FN;
   localparam logic [17:0] W_ALUWB_R = B_RW | B_RDST | B_DONE;
   localparam logic [17:0] W_ALUWB_I = B_RW | B_DONE;
   localparam logic [17:0] W_BRANCH  = B_SRCA | ALU_SUB | B_PCWC | PCS_OUT | B_DONE;
   localparam logic [17:0] W_JUMP    = B_PCW | PCS_J | B_DONE;

   localparam logic [5:0] RT  = 6'b000000;
   localparam logic [5:0] ADI = 6'b001000;
   localparam logic [5:0] LW  = 6'b100011;
   localparam logic [5:0] SW  = 6'b101011;
   localparam logic [5:0] BEQ = 6'b000100;
   localparam logic [5:0] J   = 6'b000010;
   localparam logic [5:0] BAD = 6'b111111;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   multicycle_control_if bus ();

   multicycle_control dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ctrl  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model: a queue of pending steps ----------
   typedef struct {
      logic [17:0] word;      // controls asserted in this step
      logic [17:0] gate;      // controls that additionally need mem_ready
      bit          wait_mem;  // step repeats until mem_ready
      bit          retire;    // last step of the instruction
      bit          decode;    // opcode dispatch step
      bit          fetch;     // instruction fetch step
   } step_t;

   step_t plan[$];

   function automatic step_t mk(logic [17:0] w, logic [17:0] g,
                                bit wm, bit rt, bit dc, bit ft);
      step_t s;
      s.word = w; s.gate = g; s.wait_mem = wm;
      s.retire = rt; s.decode = dc; s.fetch = ft;
      return s;
   endfunction

   function automatic bit known_op(logic [5:0] o);
      return (o == RT) || (o == ADI) || (o == LW) || (o == SW) ||
             (o == BEQ) || (o == J);
   endfunction

   function automatic void push_fetch();
      plan.push_back(mk(W_FETCH, G_FETCH, 1'b1, 1'b0, 1'b0, 1'b1));
      plan.push_back(mk(W_DECODE, 18'd0, 1'b0, 1'b0, 1'b1, 1'b0));
   endfunction

   function automatic logic [17:0] model_expect();
      logic [17:0] w;
      if (plan.size() == 0) return 18'd0;
      w = plan[0].word;
      if (plan[0].decode && !known_op(bus.op)) w = w | B_DONE | B_ILL;
      if (!bus.mem_ready) w = w & ~plan[0].gate;
      return w;
   endfunction

   function automatic void model_advance();
      step_t s;
      bit    retiring;
      if (plan.size() == 0) begin
         if (bus.run) push_fetch();
         return;
      end
      s = plan[0];
      if (s.wait_mem && !bus.mem_ready) return;
      void'(plan.pop_front());
      retiring = s.retire;
      if (s.decode) begin
         case (bus.op)
            RT: begin
               plan.push_back(mk(W_EXEC, 18'd0, 1'b0, 1'b0, 1'b0, 1'b0));
               plan.push_back(mk(W_ALUWB_R, 18'd0, 1'b0, 1'b1, 1'b0, 1'b0));
            end
            ADI: begin
               plan.push_back(mk(W_MEMADR, 18'd0, 1'b0, 1'b0, 1'b0, 1'b0));
               plan.push_back(mk(W_ALUWB_I, 18'd0, 1'b0, 1'b1, 1'b0, 1'b0));
            end
            LW: begin
               plan.push_back(mk(W_MEMADR, 18'd0, 1'b0, 1'b0, 1'b0, 1'b0));
               plan.push_back(mk(W_MEMRD, 18'd0, 1'b1, 1'b0, 1'b0, 1'b0));
               plan.push_back(mk(W_MEMWB, 18'd0, 1'b0, 1'b1, 1'b0, 1'b0));
            end
            SW: begin
               plan.push_back(mk(W_MEMADR, 18'd0, 1'b0, 1'b0, 1'b0, 1'b0));
               plan.push_back(mk(W_MEMWR, B_DONE, 1'b1, 1'b1, 1'b0, 1'b0));
            end
            BEQ: plan.push_back(mk(W_BRANCH, 18'd0, 1'b0, 1'b1, 1'b0, 1'b0));
            J:   plan.push_back(mk(W_JUMP, 18'd0, 1'b0, 1'b1, 1'b0, 1'b0));
            default: retiring = 1'b1;
         endcase
      end
      if (retiring && bus.run) push_fetch();
   endfunction

   // ---------------- checking helpers ----------------
   function automatic logic [17:0] dut_word();
      return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
              bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
              bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
              bus.PCSource, bus.instr_done, bus.illegal_op};
   endfunction

   task automatic check(input string name, input logic [17:0] act,
                        input logic [17:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %05h expected %05h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [5:0] pick_op();
      case ($urandom_range(0, 7))
         0: return RT;
         1: return ADI;
         2: return LW;
         3: return SW;
         4: return BEQ;
         5: return J;
         6: return BAD;
         default: return 6'($urandom_range(0, 63));
      endcase
   endfunction

   // ---------------- directed vector table ----------------
   typedef struct {
      bit          run;
      bit          mr;
      logic [5:0]  op;
      logic [17:0] exp;
   } vec_t;

   vec_t vecs[27];

   initial begin
      // lw end to end, then stalled fetch, stalled sw, illegal op,
      // R-type retiring with run low, j retiring with run low.
      vecs[0]  = '{1'b1, 1'b1, LW,  18'd0};
      vecs[1]  = '{1'b1, 1'b1, LW,  W_FETCH};
      vecs[2]  = '{1'b1, 1'b1, LW,  W_DECODE};
      vecs[3]  = '{1'b1, 1'b1, LW,  W_MEMADR};
      vecs[4]  = '{1'b1, 1'b1, LW,  W_MEMRD};
      vecs[5]  = '{1'b1, 1'b1, LW,  W_MEMWB};
      vecs[6]  = '{1'b1, 1'b0, SW,  W_FETCH & ~G_FETCH};
      vecs[7]  = '{1'b1, 1'b0, SW,  W_FETCH & ~G_FETCH};
      vecs[8]  = '{1'b1, 1'b1, SW,  W_FETCH};
      vecs[9]  = '{1'b1, 1'b1, SW,  W_DECODE};
      vecs[10] = '{1'b1, 1'b1, SW,  W_MEMADR};
      vecs[11] = '{1'b1, 1'b0, SW,  W_MEMWR & ~B_DONE};
      vecs[12] = '{1'b1, 1'b0, SW,  W_MEMWR & ~B_DONE};
      vecs[13] = '{1'b1, 1'b0, SW,  W_MEMWR & ~B_DONE};
      vecs[14] = '{1'b1, 1'b1, SW,  W_MEMWR};
      vecs[15] = '{1'b1, 1'b1, BAD, W_FETCH};
      vecs[16] = '{1'b1, 1'b1, BAD, W_DECODE | B_DONE | B_ILL};
      vecs[17] = '{1'b1, 1'b1, RT,  W_FETCH};
      vecs[18] = '{1'b1, 1'b1, RT,  W_DECODE};
      vecs[19] = '{1'b1, 1'b1, RT,  W_EXEC};
      vecs[20] = '{1'b0, 1'b1, RT,  W_ALUWB_R};
      vecs[21] = '{1'b0, 1'b1, RT,  18'd0};
      vecs[22] = '{1'b1, 1'b1, J,   18'd0};
      vecs[23] = '{1'b1, 1'b1, J,   W_FETCH};
      vecs[24] = '{1'b1, 1'b1, J,   W_DECODE};
      vecs[25] = '{1'b0, 1'b1, J,   W_JUMP};
      vecs[26] = '{1'b0, 1'b1, J,   18'd0};

      total         = 0;
      bad           = 0;
      rst_n         = 1'b0;
      bus.run       = 1'b0;
      bus.mem_ready = 1'b0;
      bus.op        = 6'd0;

      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", dut_word(), 18'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 27; i++) begin
         bus.run       = vecs[i].run;
         bus.mem_ready = vecs[i].mr;
         bus.op        = vecs[i].op;
         #1;
         check($sformatf("vec%0d", i), dut_word(), vecs[i].exp);
         @(posedge clk);
         #1;
      end

      // ---- reset pulled low while a store waits on memory ----
      bus.run = 1'b1; bus.mem_ready = 1'b1; bus.op = SW;
      repeat (4) tick();                       // FETCH, DECODE, MEMADR, MEMWR
      bus.mem_ready = 1'b0;
      #1;
      check("sw_waiting", dut_word(), W_MEMWR & ~B_DONE);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_drops_memwrite", dut_word(), 18'd0);
      tick();
      check("rst_held", dut_word(), 18'd0);
      rst_n   = 1'b1;
      bus.run = 1'b0;
      tick();
      check("idle_after_rst", dut_word(), 18'd0);
      bus.run = 1'b1;
      tick();
      check("fetch_after_rst", dut_word(), W_FETCH & ~G_FETCH);

      // ---- run dropped while a beq is in flight ----
      bus.mem_ready = 1'b1; bus.op = BEQ;
      tick();
      check("beq_decode", dut_word(), W_DECODE);
      bus.run = 1'b0;
      tick();
      check("beq_branch", dut_word(), W_BRANCH);
      tick();
      check("beq_then_idle", dut_word(), 18'd0);
      tick();
      check("idle_stays", dut_word(), 18'd0);

      // ---- random phase against the step-list model ----
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      plan.delete();
      for (int c = 0; c < 800; c++) begin
         bus.run       = ($urandom_range(0, 3) != 0);
         bus.mem_ready = ($urandom_range(0, 4) > 1);
         if (plan.size() == 0 || plan[0].fetch) bus.op = pick_op();
         #1;
         check("random", dut_word(), model_expect());
         @(posedge clk);
         model_advance();
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle sequencer for the MIPS datapath; replaces the single-cycle opcode decoder once PC, IR, MDR, A/B and ALUOut registers are in place.
- Walks each instruction through fetch, decode, execute, memory and writeback steps.
- Drives every datapath enable and mux select from its state.
- Waits on a ready/valid handshake from the shared instruction/data memory.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_ADDI, 6'b001000, addi opcode
OP_LW, 6'b100011, lw opcode
OP_SW, 6'b101011, sw opcode
OP_BEQ, 6'b000100, beq opcode
OP_J, 6'b000010, j opcode

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level; allows a new fetch to start
op  in  6  IR[31:26]; valid from DECODE onward
mem_ready  in  1  memory completed the current read/write this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load qualified by ALU zero (beq)
IorD  out  1  0 = PC addresses memory, 1 = ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  IR load
MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR
RegDst  out  1  destination register: 0 = rt, 1 = rd
RegWrite  out  1  register file write
ALUSrcA  out  1  ALU A input: 0 = PC, 1 = A
ALUSrcB  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
ALUOp  out  2  00 = add, 01 = sub, 10 = funct field
PCSource  out  2  PC input: 00 = ALU result, 01 = ALUOut, 10 = jump target
instr_done  out  1  one-cycle pulse as an instruction retires
illegal_op  out  1  one-cycle pulse on an unknown opcode

Behaviour:
- State register: 4 bits. Async clear to IDLE when rst_n = 0. All other logic synchronous to rising clk.
- Outputs are a pure decode of state, except where noted as gated by mem_ready (those are combinational ANDs).
- Every output not listed for a state is 0.
- In IDLE and during reset, all outputs are 0.
- Per-state outputs and transitions:
  - IDLE: no outputs. run = 1 -> FETCH, else stay.
  - FETCH: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00. IRWrite and PCWrite = mem_ready. mem_ready = 0 -> stay; mem_ready = 1 -> DECODE.
  - DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (branch target into ALUOut). Next state by op:
    - RTYPE -> EXEC
    - ADDI, LW, SW -> MEMADR
    - BEQ -> BRANCH
    - J -> JUMP
    - any other op -> illegal_op = 1 and instr_done = 1 this cycle, then -> FETCH if run else IDLE.
  - MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. LW -> MEMRD, SW -> MEMWR, ADDI -> ALUWB_I. op is held stable by the IR, so it is re-decoded here.
  - MEMRD: MemRead = 1, IorD = 1. Stay until mem_ready, then -> MEMWB.
  - MEMWB: RegWrite = 1, MemtoReg = 1, RegDst = 0, instr_done = 1.
  - MEMWR: MemWrite = 1, IorD = 1. Stay until mem_ready. instr_done = mem_ready.
  - EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10 -> ALUWB_R.
  - ALUWB_R: RegWrite = 1, RegDst = 1, MemtoReg = 0, instr_done = 1.
  - ALUWB_I: RegWrite = 1, RegDst = 0, MemtoReg = 0, instr_done = 1.
  - BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01, instr_done = 1.
  - JUMP: PCWrite = 1, PCSource = 10, instr_done = 1.
- Retire rule: every state that asserts instr_done (when it completes) goes to FETCH if run = 1, else IDLE. run is only sampled at these points and in IDLE. Deasserting run mid-instruction never aborts the instruction.
- Latency with mem_ready tied to 1:
  - lw: 5 cycles
  - sw, addi, R-type: 4 cycles
  - beq, j: 3 cycles
  - Each cycle mem_ready is held low adds one cycle to the FETCH/MEMRD/MEMWR step.
- MemRead and MemWrite are held constant while waiting for mem_ready. They are never both 1.
- Unused state encodings -> IDLE on the next clock with all outputs 0.
- Reset asserted mid-instruction: state goes to IDLE at once and all outputs drop to 0 at once. There are no partial writes after reset asserts.

Test Plan:
- Reset then run = 1, mem_ready = 1, op = 6'b100011 (lw) -> states IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. RegWrite = 1 and MemtoReg = 1 only in MEMWB. instr_done pulses once.
- R-type op = 0 -> EXEC drives ALUOp = 10; ALUWB_R drives RegWrite = 1, RegDst = 1; instr_done on cycle 4 after FETCH entry.
- sw with mem_ready low for 3 cycles in MEMWR -> MemWrite = 1, IorD = 1 held for 4 cycles; instr_done only on the mem_ready cycle; RegWrite stays 0 throughout.
- FETCH with mem_ready low for 2 cycles -> IRWrite and PCWrite stay 0 until the third cycle, then pulse for exactly 1 cycle.
- op = 6'b111111 -> illegal_op = 1 and instr_done = 1 in DECODE; no RegWrite, MemWrite or PCWrite; next state FETCH.
- Two cases:
  - rst_n pulled low during MEMWR -> MemWrite = 0 within the same cycle; state IDLE.
  - run dropped during beq -> beq completes (PCWriteCond = 1 in BRANCH), then state IDLE.
